// File: rtl/memory_stage.sv
// Memory stage: non-memory ops go straight through to a registered
// writeback bundle; LOAD/STORE hold a registered memory request until
// mem_ack arrives or the wait counter hits TIMEOUT.
module memory_stage #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        valid_in,
   input  logic [4:0]  control_in,
   input  logic [4:0]  dest_index_in,
   input  logic [15:0] result_in,
   input  logic [15:0] store_data_in,
   input  logic        reg_write_en_in,
   output logic        stall,
   output logic        mem_req,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata,
   input  logic        mem_ack,
   output logic        wb_valid,
   output logic        wb_write_en,
   output logic [4:0]  wb_dest_index,
   output logic [15:0] wb_data,
   output logic        mem_error
);

   typedef enum logic [1:0] {IDLE, WAIT_RD, WAIT_WR} state_t;

   localparam logic [3:0] OP_NOP   = 4'd0;
   localparam logic [3:0] OP_JUMP  = 4'd6;
   localparam logic [3:0] OP_JNE   = 4'd10;
   localparam logic [3:0] OP_CMP   = 4'd11;
   localparam logic [3:0] OP_LOAD  = 4'd12;
   localparam logic [3:0] OP_STORE = 4'd14;
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t      state, state_nxt;
   logic [7:0]  wait_cnt;
   logic [4:0]  pend_dest;
   logic [3:0]  op;
   logic        accept, in_wait, timeout_hit, no_write;
   logic        unused_ctrl_bit;

   assign op              = control_in[3:0];
   assign unused_ctrl_bit = control_in[4];
   assign accept          = (state == IDLE) && valid_in;
   assign in_wait         = (state != IDLE);
   assign timeout_hit     = in_wait && !mem_ack && (wait_cnt == CNT_LAST);
   // Control-flow and compare ops never write the register file.
   assign no_write        = (op == OP_NOP) || (op == OP_CMP) ||
                            ((op >= OP_JUMP) && (op <= OP_JNE));
   assign stall           = in_wait;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next state: enter WAIT on LOAD/STORE, leave on ack or timeout.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept && op == OP_LOAD)       state_nxt = WAIT_RD;
            else if (accept && op == OP_STORE) state_nxt = WAIT_WR;
         end
         WAIT_RD, WAIT_WR: begin
            if (mem_ack || timeout_hit) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Registered memory request, wait counter, writeback bundle and error flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         wait_cnt      <= '0;
         pend_dest     <= '0;
         mem_req       <= 1'b0;
         mem_we        <= 1'b0;
         mem_addr      <= '0;
         mem_wdata     <= '0;
         wb_valid      <= 1'b0;
         wb_write_en   <= 1'b0;
         wb_dest_index <= '0;
         wb_data       <= '0;
         mem_error     <= 1'b0;
      end else begin
         wb_valid    <= 1'b0;
         wb_write_en <= 1'b0;
         if (state == IDLE) begin
            if (accept) begin
               if (op == OP_LOAD || op == OP_STORE) begin
                  mem_req   <= 1'b1;
                  mem_we    <= (op == OP_STORE);
                  mem_addr  <= result_in;
                  wait_cnt  <= '0;
                  pend_dest <= dest_index_in;
                  if (op == OP_STORE) mem_wdata <= store_data_in;
               end else begin
                  wb_valid      <= 1'b1;
                  wb_write_en   <= reg_write_en_in && !no_write;
                  wb_dest_index <= dest_index_in;
                  wb_data       <= result_in;
               end
            end
         end else begin
            // Ack takes priority over a coincident timeout.
            if (mem_ack) begin
               mem_req       <= 1'b0;
               mem_we        <= 1'b0;
               wb_valid      <= 1'b1;
               wb_write_en   <= (state == WAIT_RD);
               wb_dest_index <= pend_dest;
               if (state == WAIT_RD) wb_data <= mem_rdata;
            end else if (timeout_hit) begin
               mem_req       <= 1'b0;
               mem_we        <= 1'b0;
               mem_error     <= 1'b1;
               wb_valid      <= 1'b1;
               wb_dest_index <= pend_dest;
            end else begin
               wait_cnt <= wait_cnt + 8'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage (TIMEOUT=4 so the timeout path is short).
module tb_memory_stage;

   logic        clk = 1'b0;
   logic        reset, valid_in, reg_write_en_in, mem_ack;
   logic [4:0]  control_in, dest_index_in;
   logic [15:0] result_in, store_data_in, mem_rdata;
   logic        stall, mem_req, mem_we, wb_valid, wb_write_en, mem_error;
   logic [15:0] mem_addr, mem_wdata, wb_data;
   logic [4:0]  wb_dest_index;

   int n_chk = 0;
   int n_err = 0;

   memory_stage #(.TIMEOUT(4)) dut (
      .clk(clk), .reset(reset), .valid_in(valid_in), .control_in(control_in),
      .dest_index_in(dest_index_in), .result_in(result_in),
      .store_data_in(store_data_in), .reg_write_en_in(reg_write_en_in),
      .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .wb_valid(wb_valid), .wb_write_en(wb_write_en),
      .wb_dest_index(wb_dest_index), .wb_data(wb_data), .mem_error(mem_error)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [3:0] op, input logic [4:0] dest,
                        input logic [15:0] res, input logic [15:0] sd, input logic we);
      valid_in        = 1'b1;
      control_in      = {1'b0, op};
      dest_index_in   = dest;
      result_in       = res;
      store_data_in   = sd;
      reg_write_en_in = we;
      tick();
      valid_in        = 1'b0;
   endtask

   initial begin
      reset = 1'b1; valid_in = 1'b0; control_in = '0; dest_index_in = '0;
      result_in = '0; store_data_in = '0; reg_write_en_in = 1'b0;
      mem_rdata = '0; mem_ack = 1'b0;
      tick(); tick();
      chk("rst_stall", stall, 0);
      chk("rst_req", mem_req, 0);
      chk("rst_we", mem_we, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_wvalid", wb_valid, 0);
      chk("rst_wdata", wb_data, 0);
      chk("rst_err", mem_error, 0);
      reset = 1'b0;

      // ADD passes straight through
      issue(4'd2, 5'd2, 16'd15, 16'd0, 1'b1);
      chk("add_valid", wb_valid, 1);
      chk("add_we", wb_write_en, 1);
      chk("add_dest", wb_dest_index, 2);
      chk("add_data", wb_data, 15);
      chk("add_stall", stall, 0);
      tick();
      chk("idle_valid", wb_valid, 0);
      chk("idle_hold", wb_data, 15);

      // LOAD, ack in 3rd WAIT cycle
      mem_rdata = 16'hBEEF;
      issue(4'd12, 5'd5, 16'h0040, 16'd0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         chk("ld_req", mem_req, 1);
         chk("ld_addr", mem_addr, 16'h0040);
         chk("ld_we", mem_we, 0);
         chk("ld_stall", stall, 1);
         chk("ld_nowb", wb_valid, 0);
         if (i == 2) mem_ack = 1'b1;
         if (i < 2) tick();
      end
      tick();
      mem_ack = 1'b0;
      chk("ld_done_req", mem_req, 0);
      chk("ld_done_stall", stall, 0);
      chk("ld_wvalid", wb_valid, 1);
      chk("ld_wwe", wb_write_en, 1);
      chk("ld_wdata", wb_data, 16'hBEEF);
      chk("ld_wdest", wb_dest_index, 5);

      // STORE, ack in 1st WAIT cycle
      issue(4'd14, 5'd1, 16'h0010, 16'h1234, 1'b0);
      chk("st_req", mem_req, 1);
      chk("st_we", mem_we, 1);
      chk("st_addr", mem_addr, 16'h0010);
      chk("st_wdata", mem_wdata, 16'h1234);
      mem_ack = 1'b1;
      tick();
      chk("st_done_req", mem_req, 0);
      chk("st_wvalid", wb_valid, 1);
      chk("st_wwe", wb_write_en, 0);
      chk("st_err", mem_error, 0);

      // Ack while IDLE is ignored
      tick();
      mem_ack = 1'b0;
      chk("idle_ack_valid", wb_valid, 0);
      chk("idle_ack_stall", stall, 0);

      // Reset in 2nd WAIT cycle of a LOAD
      issue(4'd12, 5'd6, 16'h0022, 16'd0, 1'b1);
      tick();
      chk("rw_req", mem_req, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rw_req0", mem_req, 0);
      chk("rw_valid0", wb_valid, 0);
      chk("rw_err0", mem_error, 0);
      chk("rw_stall0", stall, 0);

      // Ack coinciding with timeout: ack wins
      issue(4'd12, 5'd7, 16'h0033, 16'd0, 1'b1);
      mem_rdata = 16'h5A5A;
      tick(); tick(); tick();
      chk("co_req", mem_req, 1);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      chk("co_wwe", wb_write_en, 1);
      chk("co_wdata", wb_data, 16'h5A5A);
      chk("co_err", mem_error, 0);

      // LOAD timeout with TIMEOUT=4
      issue(4'd12, 5'd8, 16'h0044, 16'd0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         chk("to_req", mem_req, 1);
         tick();
      end
      chk("to_req0", mem_req, 0);
      chk("to_err", mem_error, 1);
      chk("to_wvalid", wb_valid, 1);
      chk("to_wwe", wb_write_en, 0);
      chk("to_stall", stall, 0);
      issue(4'd2, 5'd3, 16'd9, 16'd0, 1'b1);
      chk("to_add_valid", wb_valid, 1);
      chk("to_add_data", wb_data, 9);
      chk("to_err_sticky", mem_error, 1);

      // Back-to-back JUMP, CMP, MOV
      valid_in = 1'b1; reg_write_en_in = 1'b1;
      control_in = 5'd6;  dest_index_in = 5'd1; result_in = 16'd1;
      tick();
      chk("b2b_j_valid", wb_valid, 1);
      chk("b2b_j_we", wb_write_en, 0);
      control_in = 5'd11; dest_index_in = 5'd2; result_in = 16'd2;
      tick();
      chk("b2b_c_valid", wb_valid, 1);
      chk("b2b_c_we", wb_write_en, 0);
      control_in = 5'd15; dest_index_in = 5'd4; result_in = 16'd7;
      tick();
      valid_in = 1'b0;
      chk("b2b_m_valid", wb_valid, 1);
      chk("b2b_m_we", wb_write_en, 1);
      chk("b2b_m_data", wb_data, 7);
      chk("b2b_m_dest", wb_dest_index, 4);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255; the maximum number of WAIT cycles without mem_ack before an access is aborted (range 1..255).
REQ-002 SHALL have port clk, input, 1; the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1; synchronous, active-high reset.
REQ-004 SHALL have port valid_in, input, 1; the Execute-stage outputs below hold a valid instruction.
REQ-005 SHALL have port control_in, input, 5; opcode in bits [3:0] (NOP=0, SUB=1, ADD=2, ADDI=3, SHLLI=4, SHRLI=5, JUMP..JUMPNE=6..10, CMP=11, LOAD=12, LOADI=13, STORE=14, MOV=15); bit 4 ignored.
REQ-006 SHALL have port dest_index_in, input, 5; destination register index.
REQ-007 SHALL have port result_in, input, 16; ALU result, which is also the memory address for LOAD/STORE.
REQ-008 SHALL have port store_data_in, input, 16; data to be written by STORE.
REQ-009 SHALL have port reg_write_en_in, input, 1; Execute's DEST_REG_WRITE_EN.
REQ-010 SHALL have port stall, output, 1; upstream SHALL hold its outputs while this is high.
REQ-011 SHALL have ports mem_req, mem_we, mem_addr[15:0], mem_wdata[15:0], outputs; the data-memory request.
REQ-012 SHALL have ports mem_rdata[15:0], mem_ack, inputs; the data-memory response.
REQ-013 SHALL have ports wb_valid, wb_write_en, wb_dest_index[4:0], wb_data[15:0], outputs; the writeback bundle.
REQ-014 SHALL have port mem_error, output, 1; sticky timeout flag.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT_RD, WAIT_WR.
REQ-016 SHALL drive stall = (state != IDLE), from registered state only.
REQ-017 SHALL accept an instruction only when valid_in=1 in IDLE; valid_in is ignored in WAIT states.
REQ-018 For an accepted non-memory op (all except LOAD/STORE), SHALL assert these outputs for exactly the next cycle: wb_valid=1, wb_dest_index=dest_index_in, wb_data=result_in.
REQ-019 wb_write_en for non-memory ops SHALL be reg_write_en_in, forced 0 for NOP, JUMP..JUMPNE and CMP; LOADI and MOV write result_in.
REQ-020 Accepted LOAD SHALL register mem_addr=result_in, mem_we=0 and mem_req=1 from the next cycle, and SHALL go to WAIT_RD.
REQ-021 Accepted STORE SHALL register mem_addr=result_in, mem_wdata=store_data_in, mem_we=1 and mem_req=1 from the next cycle, and SHALL go to WAIT_WR.
REQ-022 mem_req, mem_we, mem_addr and mem_wdata SHALL be held stable for the whole WAIT state.
REQ-023 mem_ack SHALL be sampled only in WAIT states; an ack in IDLE is ignored; an ack in the first WAIT cycle is legal.
REQ-024 On ack in WAIT_RD, the next cycle SHALL give: mem_req=0, state IDLE, wb_valid=1, wb_write_en=1, wb_data=mem_rdata sampled in the ack cycle.
REQ-025 On ack in WAIT_WR, the next cycle SHALL give: mem_req=0, state IDLE, wb_valid=1, wb_write_en=0.
REQ-026 An 8-bit wait counter SHALL clear on entry to WAIT and increment each WAIT cycle without ack.
REQ-027 A WAIT cycle with no ack and counter==TIMEOUT-1 SHALL cause, next cycle: state IDLE, mem_req=0, mem_error=1, wb_valid=1, wb_write_en=0.
REQ-028 If ack and timeout coincide, ack SHALL win (normal completion, no error).
REQ-029 mem_error SHALL be cleared only by reset.
REQ-030 Throughput SHALL be one non-memory instruction per cycle; a memory op SHALL occupy at least 2 cycles.
REQ-031 In cycles with no writeback, wb_valid and wb_write_en SHALL be 0; wb_data and wb_dest_index SHALL hold their last value.

Reset
REQ-032 When reset=1 at a clock edge: state=IDLE, counter=0, and all outputs 0 (stall, mem_req, mem_we, mem_addr, mem_wdata, wb_valid, wb_write_en, wb_dest_index, wb_data, mem_error).
REQ-033 Reset during WAIT SHALL abort the access with mem_req=0 the next cycle and produce no writeback.

Verification
REQ-034 ADD with result_in=15, dest=2, reg_write_en_in=1 -> next cycle wb_valid=1, wb_write_en=1, wb_dest_index=2, wb_data=15, stall=0.
REQ-035 LOAD with result_in=0x0040, mem_rdata=0xBEEF, ack in 3rd WAIT cycle -> mem_req high 3 cycles with addr 0x0040 and we=0, stall high 3 cycles, then wb_data=0xBEEF, wb_write_en=1.
REQ-036 STORE with result_in=0x0010, store_data_in=0x1234, ack in 1st WAIT cycle -> one req cycle with we=1, wdata=0x1234, then wb_valid=1, wb_write_en=0.
REQ-037 LOAD with TIMEOUT=4 and no ack -> 4 req cycles, then mem_error=1, wb_write_en=0; mem_error stays 1 through a following ADD.
REQ-038 Reset asserted in the 2nd WAIT cycle of a LOAD -> mem_req=0, wb_valid=0, mem_error=0 the next cycle.
REQ-039 Back-to-back JUMP, CMP, MOV(result_in=7) -> three consecutive wb_valid cycles with wb_write_en 0, 0, 1.
